uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Next-generation UART receiver with an oversampling front end.
Generalises the fixed 8N1 receiver to a configurable frame: data width, parity mode and stop-bit count are parameters.
Adds majority-vote sampling, parity, framing, break and overrun reporting, and a valid/ready output.
Sits between the pad-side serial line and byte-consuming logic; pairs with UART_Tx in loopback benches.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, >=8
DATA_BITS, 8, payload bits per frame, 5..9
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, input synchroniser depth, >=2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rx_serial  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received payload, LSB = first bit on the line
rx_valid  out  1  rx_data and the per-frame error flags are valid
rx_ready  in  1  consumer accepts the frame when rx_valid && rx_ready
parity_err  out  1  per-frame flag, qualified by rx_valid
frame_err  out  1  per-frame flag, qualified by rx_valid; stop bit sampled low
overrun  out  1  sticky; a frame was lost because rx_valid was still held
break_det  out  1  one-cycle pulse on break detection
rx_busy  out  1  FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: all outputs 0; rx_data 0; synchroniser flops 1 (line idle); FSM in IDLE; tick counter 0.
- Reset mid-frame aborts immediately. No partial frame is delivered.
- Tick: DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), rounded. Defaults give DIV = 27, so 1 bit = 432 clk.
- The tick divider restarts on start-edge detection so that sampling phase aligns to the edge.
- Sampling: each bit is decided by a 2-of-3 majority of the synchronised line at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- FSM states:
  - IDLE -> START on a synchronised 1->0 transition.
  - START: if the majority vote is 1, the start is false; return to IDLE with no flags. Otherwise go to DATA.
  - DATA: DATA_BITS bits, LSB first, shifted into a working register. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: one bit. The check is computed over the data bits plus the parity bit; for odd parity the total count of ones must be odd, for even parity it must be even.
  - STOP: STOP_BITS bits. Any stop bit voting 0 sets frame_err for the frame.
  - The FSM returns to IDLE right after the mid-bit decision of the last stop bit. It does not wait for the end of the bit, so that a new start edge can be detected.
- Break: if all data bits, the parity bit (if present) and the first stop bit all vote 0, the FSM pulses break_det for 1 cycle and delivers nothing. It then enters BRK_WAIT and stays until the synchronised line is 1, then returns to IDLE.
- Delivery latency: rx_valid rises 1 clk after the last stop-bit decision. rx_data, parity_err and frame_err load together with it and hold stable until the handshake.
- Handshake: a frame transfers when rx_valid && rx_ready. rx_valid then drops the next cycle unless a new frame completes in that same cycle.
- Simultaneous handshake and new frame completion: the new frame loads, rx_valid stays 1, and no overrun is raised.
- Overrun: if a frame completes while rx_valid=1 and rx_ready=0, the new frame is discarded and the old frame is retained.
  - overrun sets and stays 1 until the next handshake. It clears in the cycle after the handshake.
- rx_busy is 1 in every state except IDLE.
- Assertions: reject DATA_BITS outside 5..9, PARITY > 2, STOP_BITS outside {1,2}, and odd OVERSAMPLE at elaboration.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings PAR_NONE / PAR_ODD / PAR_EVEN;
  - FSM state encoding S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK;
  - a constant function that computes the rounded DIV.
- One sub-module: uart_baud_tick. It takes DIV, outputs a one-clk tick pulse, and has a synchronous restart input.
- The synchroniser stays inline.

Test Plan:
- 8N1, send 0xA5 with rx_ready=1 -> rx_valid pulses once about 9.5 bit times after the start edge; rx_data=0xA5, both error flags 0.
- PARITY=2, send 0x3C with correct parity, then 0x3C with the parity bit flipped -> first frame has parity_err=0; second has rx_data=0x3C, parity_err=1.
- Stop bit forced low on 0x5A -> frame_err=1, rx_data=0x5A. Then hold the line low for 20 bit times -> break_det pulses once, no rx_valid, FSM waits in S_BRK until the line rises.
- rx_ready=0, send 0xFF then 0x00 -> rx_data stays 0xFF and overrun=1. Pulse rx_ready -> overrun=0 and rx_valid=0 the following cycle.
- Glitch test: a 100 ns low pulse on the idle line -> false start rejected, no flags set, rx_busy returns to 0 within 1 bit time.
- Clock mismatch: transmitter clock 50 MHz, receiver clock 49.5 MHz, bytes 0xC3 and 0x3C sent back-to-back with 1 stop bit -> both received intact. Then assert rst mid-frame -> all outputs 0 immediately and no partial frame delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity modes,
// FSM state encoding and the baud divider calculation.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BRK   = 3'd5
  } rx_state_e;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int calc_div(input longint clk_freq, input longint baud_rate,
                                  input longint oversample);
    longint den;
    den = baud_rate * oversample;
    return int'((clk_freq + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator; restart realigns the phase so the
// first tick lands DIV clocks after the restart cycle.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= CW'(DIV - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit decisions, parity, framing
// and break detection, and a valid/ready output with sticky overrun.
//
// state   | meaning
// S_IDLE  | waiting for a 1->0 edge on the synchronised line
// S_START | validating the start bit at mid-bit
// S_DATA  | shifting in payload bits, LSB first
// S_PAR   | capturing the parity bit
// S_STOP  | checking stop bit(s); leaves right after the last mid-bit vote
// S_BRK   | break seen; waiting for the line to return high
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 rx_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_os: DATA_BITS must be within 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_os: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  rx_state_e              state;
  logic [TCW-1:0]         tick_idx;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   stop_err;
  logic                   samp_a;
  logic                   samp_b;
  logic                   tick;
  logic                   start_edge;
  logic                   vote_tick;
  logic                   vote;
  logic                   par_calc;
  logic                   par_bad;
  logic                   is_break;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = (state == S_IDLE) && rx_prev && !rx_s;
  assign vote_tick  = tick && (tick_idx == TCW'(MID + 1));
  assign vote       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign par_calc   = ^{shreg, par_bit};
  assign par_bad    = (PARITY == PAR_ODD)  ? ~par_calc :
                      (PARITY == PAR_EVEN) ?  par_calc : 1'b0;
  // par_bit is cleared at frame start, so it reads 0 when no parity bit exists
  assign is_break   = (shreg == '0) && !par_bit && !vote;
  assign rx_busy    = (state != S_IDLE);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(start_edge),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev    <= 1'b1;
      state      <= S_IDLE;
      tick_idx   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_err   <= 1'b0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_prev   <= rx_s;
      break_det <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      if (tick) begin
        tick_idx <= (tick_idx == TCW'(OVERSAMPLE - 1)) ? '0 : tick_idx + 1'b1;
        if (tick_idx == TCW'(MID - 1)) samp_a <= rx_s;
        if (tick_idx == TCW'(MID))     samp_b <= rx_s;
      end

      // State changes happen at the mid-bit vote; tick_idx keeps running
      // modulo OVERSAMPLE so the next vote falls one bit later.
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state    <= S_START;
            tick_idx <= '0;
          end
        end
        S_START: begin
          if (vote_tick) begin
            state    <= vote ? S_IDLE : S_DATA;
            bit_cnt  <= '0;
            par_bit  <= 1'b0;
            stop_err <= 1'b0;
          end
        end
        S_DATA: begin
          if (vote_tick) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY == PAR_NONE) ? S_STOP : S_PAR;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (vote_tick) begin
            par_bit <= vote;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (vote_tick) begin
            if (bit_cnt == '0 && is_break) begin
              break_det <= 1'b1;
              state     <= S_BRK;
            end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
              state <= S_IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data    <= shreg;
                parity_err <= par_bad;
                frame_err  <= stop_err | ~vote;
                rx_valid   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              stop_err <= stop_err | ~vote;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        S_BRK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 instance and an even-parity instance
// share one serial line driven from a time-based transmitter model.
module tb_uart_rx_os;

  // Transmitter bit time: 432 clocks of a 50 MHz clock, in ps.
  localparam int BIT_PS = 8_640_000;

  int   clk_half = 10_000;
  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic line     = 1'b1;
  logic ready_a  = 1'b1;
  logic ready_p  = 1'b1;

  logic [7:0] a_data, p_data;
  logic a_valid, a_pe, a_fe, a_ovr, a_brk, a_busy;
  logic p_valid, p_pe, p_fe, p_ovr, p_brk, p_busy;

  int n_cmp = 0;
  int n_err = 0;

  int         a_rise  = 0;
  int         a_brk_n = 0;
  int         a_log_n = 0;
  logic       a_valid_q = 1'b0;
  logic [7:0] a_log    [0:31];
  logic       a_log_fe [0:31];

  int         cap_cyc;
  logic [7:0] cap_data;
  logic       cap_pe, cap_fe, cap_vafter;

  always #(clk_half * 1ps) clk = ~clk;

  uart_rx_os u_dut (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (line),
    .rx_data   (a_data),
    .rx_valid  (a_valid),
    .rx_ready  (ready_a),
    .parity_err(a_pe),
    .frame_err (a_fe),
    .overrun   (a_ovr),
    .break_det (a_brk),
    .rx_busy   (a_busy)
  );

  uart_rx_os #(
    .PARITY(2)
  ) u_dut_par (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (line),
    .rx_data   (p_data),
    .rx_valid  (p_valid),
    .rx_ready  (ready_p),
    .parity_err(p_pe),
    .frame_err (p_fe),
    .overrun   (p_ovr),
    .break_det (p_brk),
    .rx_busy   (p_busy)
  );

  always @(negedge clk) begin
    a_valid_q <= a_valid;
    if (a_valid && !a_valid_q) a_rise <= a_rise + 1;
    if (a_brk) a_brk_n <= a_brk_n + 1;
    if (a_valid && ready_a) begin
      a_log[a_log_n[4:0]]    <= a_data;
      a_log_fe[a_log_n[4:0]] <= a_fe;
      a_log_n                <= a_log_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #(100_000 * 1ps);
    rst = 1'b1;
    #(100_000 * 1ps);
  endtask

  // pbit < 0 means no parity bit on the line.
  task automatic send_frame(input logic [7:0] d, input int pbit, input logic stop_lvl);
    line = 1'b0;
    #(BIT_PS * 1ps);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      #(BIT_PS * 1ps);
    end
    if (pbit >= 0) begin
      line = pbit[0];
      #(BIT_PS * 1ps);
    end
    line = stop_lvl;
    #(BIT_PS * 1ps);
    line = 1'b1;
  endtask

  // Sends one frame and captures the selected receiver's output at the first
  // negedge where rx_valid is seen, plus rx_valid one cycle later.
  task automatic xfer(input int sel, input logic [7:0] d, input int pbit, input logic stop_lvl);
    @(negedge clk);
    fork
      send_frame(d, pbit, stop_lvl);
      begin
        cap_cyc = 0;
        while (!(sel != 0 ? p_valid : a_valid) && cap_cyc < 6000) begin
          @(negedge clk);
          cap_cyc++;
        end
        cap_data = (sel != 0) ? p_data : a_data;
        cap_pe   = (sel != 0) ? p_pe   : a_pe;
        cap_fe   = (sel != 0) ? p_fe   : a_fe;
        @(negedge clk);
        cap_vafter = (sel != 0) ? p_valid : a_valid;
      end
    join
  endtask

  initial begin
    int rise0, brk0, log0;

    #(1_000 * 1ps) rst = 1'b0;
    #(50_000 * 1ps);
    check("reset_a", 32'({a_data, a_valid, a_pe, a_fe, a_ovr, a_brk, a_busy}), 32'h0);
    check("reset_p", 32'({p_data, p_valid, p_pe, p_fe, p_ovr, p_brk, p_busy}), 32'h0);
    rst = 1'b1;
    #(200_000 * 1ps);

    // 8N1 0xA5: 3 clk sync+edge, 10 ticks of 27 to the start vote, 9 bits of 432.
    xfer(0, 8'hA5, -1, 1'b1);
    check("a5_timeout", 32'(cap_cyc < 6000), 32'd1);
    check("a5_latency", 32'(cap_cyc), 32'd4161);
    check("a5_data", 32'(cap_data), 32'hA5);
    check("a5_errs", 32'({cap_pe, cap_fe}), 32'h0);
    check("a5_one_cycle", 32'(cap_vafter), 32'h0);
    check("a5_rise_count", 32'(a_rise), 32'd1);

    // Even parity: 0x3C has four ones, so the correct parity bit is 0.
    do_reset();
    xfer(1, 8'h3C, 0, 1'b1);
    check("par_ok_timeout", 32'(cap_cyc < 6000), 32'd1);
    check("par_ok_data", 32'(cap_data), 32'h3C);
    check("par_ok_errs", 32'({cap_pe, cap_fe}), 32'h0);
    xfer(1, 8'h3C, 1, 1'b1);
    check("par_bad_timeout", 32'(cap_cyc < 6000), 32'd1);
    check("par_bad_data", 32'(cap_data), 32'h3C);
    check("par_bad_errs", 32'({cap_pe, cap_fe}), 32'h2);

    // Framing error, then a long low line for break.
    do_reset();
    xfer(0, 8'h5A, -1, 1'b0);
    check("fe_timeout", 32'(cap_cyc < 6000), 32'd1);
    check("fe_data", 32'(cap_data), 32'h5A);
    check("fe_errs", 32'({cap_pe, cap_fe}), 32'h1);
    #(2 * BIT_PS * 1ps);
    brk0  = a_brk_n;
    rise0 = a_rise;
    line  = 1'b0;
    #(19 * BIT_PS * 1ps);
    check("brk_busy_waiting", 32'(a_busy), 32'd1);
    check("brk_pulses", 32'(a_brk_n - brk0), 32'd1);
    check("brk_no_valid", 32'(a_rise - rise0), 32'd0);
    line = 1'b1;
    #(BIT_PS * 1ps);
    check("brk_back_idle", 32'(a_busy), 32'd0);

    // Overrun: 0xFF held, 0x00 lost.
    do_reset();
    ready_a = 1'b0;
    xfer(0, 8'hFF, -1, 1'b1);
    check("ovr_first_timeout", 32'(cap_cyc < 6000), 32'd1);
    check("ovr_first_data", 32'(cap_data), 32'hFF);
    check("ovr_first_held", 32'(cap_vafter), 32'd1);
    send_frame(8'h00, -1, 1'b1);
    @(negedge clk);
    check("ovr_data_kept", 32'(a_data), 32'hFF);
    check("ovr_flag", 32'({a_ovr, a_valid}), 32'h3);
    @(negedge clk);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    check("ovr_after_handshake", 32'({a_ovr, a_valid}), 32'h0);

    // 100 ns glitch on the idle line.
    ready_a = 1'b1;
    @(negedge clk);
    rise0 = a_rise;
    brk0  = a_brk_n;
    line  = 1'b0;
    #(100_000 * 1ps);
    line = 1'b1;
    #(300_000 * 1ps);
    check("glitch_busy", 32'(a_busy), 32'd1);
    #(BIT_PS * 1ps);
    check("glitch_idle", 32'(a_busy), 32'd0);
    check("glitch_flags", 32'({a_valid, a_pe, a_fe, a_ovr}), 32'h0);
    check("glitch_no_frame", 32'((a_rise - rise0) + (a_brk_n - brk0)), 32'd0);

    // Receiver clock at 49.5 MHz against a 50 MHz transmitter.
    clk_half = 10_101;
    do_reset();
    log0 = a_log_n;
    send_frame(8'hC3, -1, 1'b1);
    send_frame(8'h3C, -1, 1'b1);
    #(2 * BIT_PS * 1ps);
    check("mm_count", 32'(a_log_n - log0), 32'd2);
    check("mm_byte0", 32'(a_log[log0 & 31]), 32'hC3);
    check("mm_byte1", 32'(a_log[(log0 + 1) & 31]), 32'h3C);
    check("mm_fe", 32'({a_log_fe[log0 & 31], a_log_fe[(log0 + 1) & 31]}), 32'h0);

    // Reset in the middle of a frame.
    clk_half = 10_000;
    #(100_000 * 1ps);
    log0 = a_log_n;
    fork
      send_frame(8'h55, -1, 1'b1);
      begin
        #(4 * BIT_PS * 1ps);
        check("mid_busy", 32'(a_busy), 32'd1);
        rst = 1'b0;
        #(1_000 * 1ps);
        check("mid_reset_zero", 32'({a_data, a_valid, a_pe, a_fe, a_ovr, a_brk, a_busy}), 32'h0);
        #(7 * BIT_PS * 1ps);
        rst = 1'b1;
      end
    join
    #(2 * BIT_PS * 1ps);
    check("no_partial_frame", 32'(a_log_n - log0), 32'd0);
    check("post_reset_out", 32'({a_data, a_valid, a_busy}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
